// File: rtl/mesh_flit_rx.sv
// mesh_flit_rx: credit-based flit receive FIFO with packet framing check; define MESH_FLIT_RX_PKT_CNT_EN to add pkt_cnt
module mesh_flit_rx #(
  parameter int DW = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_sop,
  input  logic                       in_eop,
  output logic                       credit_ret,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill,
`ifdef MESH_FLIT_RX_PKT_CNT_EN
  output logic [31:0]                pkt_cnt,
`endif
  output logic                       frame_err,
  output logic                       ovf_err,
  input  logic                       err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state, state_nx;
  logic [DW+1:0] mem [DEPTH];
  logic [DW+1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, push, pop, fr_set, ov_set;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = push ? (in_eop ? IDLE : IN_PKT) : state;
  always_comb begin
    full = fill == FW'(DEPTH);
    ov_set = in_valid & full;
    fr_set = in_valid & ~full & (state == IDLE ? ~in_sop : in_sop);
    push = in_valid & ~full & ~fr_set;
  end
  always_comb begin
    head = mem[rd_ptr];
    out_valid = fill != '0;
    pop = out_valid & out_ready;
    out_data = out_valid ? head[DW-1:0] : '0;
    out_eop = out_valid & head[DW];
    out_sop = out_valid & head[DW+1];
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_sop, in_eop, in_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      credit_ret <= 1'b0;
      frame_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + FW'(push) - FW'(pop);
      credit_ret <= pop;
      frame_err <= fr_set | (frame_err & ~err_clr);
      ovf_err <= ov_set | (ovf_err & ~err_clr);
    end
`ifdef MESH_FLIT_RX_PKT_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) pkt_cnt <= '0;
    else if (pop & out_eop) pkt_cnt <= pkt_cnt + 32'd1;
`endif
endmodule
